// File: rtl/control_unit.sv
// Moore sequencer for the single-bus datapath: fetch (T0-T2), opcode-dependent execute (T3-T7),
// and a HALT state that only reset can leave. Memory waits stall indefinitely on mem_ready.
module control_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR,
  input  logic        Branch,
  input  logic        mem_ready,
  input  logic        stop,
  output logic        PCout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        Cout,
  output logic        BAout,
  output logic        Rout,
  output logic        MARin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        PCin,
  output logic        Zlowin,
  output logic        Rin,
  output logic        GRA,
  output logic        GRB,
  output logic        GRC,
  output logic        IncPc,
  output logic        CONin,
  output logic        read,
  output logic        write,
  output logic        run,
  output logic [1:0]  mdr_read,
  output logic [3:0]  control
);

  typedef enum logic [4:0] {RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;

  state_t     state_reg, state_next, end_state;
  logic [4:0] opcode_reg;
  logic       t1_first_reg;

  logic       is_ld, is_st, is_alu, is_imm, is_br, is_jr, is_jal, is_halt;
  logic [3:0] alu_op;

  // Only the opcode field of IR is used here.
  logic unused_ir;
  assign unused_ir = ^IR[26:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= RST;
      opcode_reg   <= 5'd0;
      t1_first_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      // PCin in T1 must fire only once even if memory stalls the fetch.
      t1_first_reg <= (state_reg == T0);
      if (state_reg == T2)
        opcode_reg <= IR[31:27];
    end
  end

  // Opcode classes; anything not listed falls through to nop behaviour.
  always_comb begin
    is_ld   = 1'b0;
    is_st   = 1'b0;
    is_alu  = 1'b0;
    is_imm  = 1'b0;
    is_br   = 1'b0;
    is_jr   = 1'b0;
    is_jal  = 1'b0;
    is_halt = 1'b0;
    alu_op  = 4'd0;
    case (opcode_reg)
      5'b00000: is_ld = 1'b1;
      5'b00010: is_st = 1'b1;
      5'b00011: begin is_alu = 1'b1; alu_op = 4'd2; end
      5'b00100: begin is_alu = 1'b1; alu_op = 4'd3; end
      5'b00101: begin is_alu = 1'b1; alu_op = 4'd4; end
      5'b00110: begin is_alu = 1'b1; alu_op = 4'd5; end
      5'b01011: begin is_imm = 1'b1; alu_op = 4'd2; end
      5'b01100: begin is_imm = 1'b1; alu_op = 4'd4; end
      5'b01101: begin is_imm = 1'b1; alu_op = 4'd5; end
      5'b10010: is_br   = 1'b1;
      5'b10011: is_jr   = 1'b1;
      5'b10100: is_jal  = 1'b1;
      5'b11011: is_halt = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    PCout      = 1'b0;
    Zlowout    = 1'b0;
    MDRout     = 1'b0;
    Cout       = 1'b0;
    BAout      = 1'b0;
    Rout       = 1'b0;
    MARin      = 1'b0;
    MDRin      = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    PCin       = 1'b0;
    Zlowin     = 1'b0;
    Rin        = 1'b0;
    GRA        = 1'b0;
    GRB        = 1'b0;
    GRC        = 1'b0;
    IncPc      = 1'b0;
    CONin      = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    mdr_read   = 2'b00;
    control    = 4'd0;
    run        = (state_reg != RST) && (state_reg != HALT);
    end_state  = stop ? HALT : T0;
    state_next = state_reg;

    case (state_reg)
      RST: state_next = T0;
      T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPc = 1'b1; Zlowin = 1'b1;
        state_next = T1;
      end
      T1: begin
        Zlowout = 1'b1; PCin = t1_first_reg; read = 1'b1;
        mdr_read = 2'b01; MDRin = 1'b1;
        if (mem_ready) state_next = T2;
      end
      T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        state_next = T3;
      end
      T3: begin
        if (is_alu || is_imm) begin
          GRB = 1'b1; Rout = 1'b1; Yin = 1'b1; state_next = T4;
        end else if (is_ld || is_st) begin
          GRB = 1'b1; BAout = 1'b1; Yin = 1'b1; state_next = T4;
        end else if (is_br) begin
          GRA = 1'b1; Rout = 1'b1; CONin = 1'b1; state_next = T4;
        end else if (is_jal) begin
          GRB = 1'b1; PCout = 1'b1; Rin = 1'b1; state_next = T4;
        end else if (is_jr) begin
          GRA = 1'b1; Rout = 1'b1; PCin = 1'b1; state_next = end_state;
        end else if (is_halt) begin
          state_next = HALT;
        end else begin
          state_next = end_state;
        end
      end
      T4: begin
        if (is_alu) begin
          GRC = 1'b1; Rout = 1'b1; control = alu_op; Zlowin = 1'b1; state_next = T5;
        end else if (is_imm) begin
          Cout = 1'b1; control = alu_op; Zlowin = 1'b1; state_next = T5;
        end else if (is_ld || is_st) begin
          Cout = 1'b1; control = 4'd2; Zlowin = 1'b1; state_next = T5;
        end else if (is_br) begin
          PCout = 1'b1; Yin = 1'b1; state_next = T5;
        end else if (is_jal) begin
          GRA = 1'b1; Rout = 1'b1; PCin = 1'b1; state_next = end_state;
        end else begin
          state_next = end_state;
        end
      end
      T5: begin
        if (is_alu || is_imm) begin
          Zlowout = 1'b1; GRA = 1'b1; Rin = 1'b1; state_next = end_state;
        end else if (is_ld || is_st) begin
          Zlowout = 1'b1; MARin = 1'b1; state_next = T6;
        end else if (is_br) begin
          Cout = 1'b1; control = 4'd2; Zlowin = 1'b1; state_next = T6;
        end else begin
          state_next = end_state;
        end
      end
      T6: begin
        if (is_ld) begin
          read = 1'b1; mdr_read = 2'b01; MDRin = 1'b1;
          if (mem_ready) state_next = T7;
        end else if (is_st) begin
          GRA = 1'b1; Rout = 1'b1; MDRin = 1'b1; state_next = T7;
        end else if (is_br) begin
          Zlowout = 1'b1; PCin = Branch; state_next = end_state;
        end else begin
          state_next = end_state;
        end
      end
      T7: begin
        if (is_ld) begin
          MDRout = 1'b1; GRA = 1'b1; Rin = 1'b1; state_next = end_state;
        end else if (is_st) begin
          write = 1'b1;
          if (mem_ready) state_next = end_state;
        end else begin
          state_next = end_state;
        end
      end
      HALT: state_next = HALT;
      default: state_next = RST;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle vectors of {inputs, expected strobes} plus
// hand-written reset/halt/abort sequences.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ir;
  logic        branch, mem_ready, stop;
  logic PCout, Zlowout, MDRout, Cout, BAout, Rout, MARin, MDRin, IRin, Yin, PCin, Zlowin;
  logic Rin, GRA, GRB, GRC, IncPc, CONin, read, write, run;
  logic [1:0] mdr_read;
  logic [3:0] control;

  control_unit dut (
    .clk(clk), .reset(reset), .IR(ir), .Branch(branch), .mem_ready(mem_ready), .stop(stop),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .Cout(Cout), .BAout(BAout),
    .Rout(Rout), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .PCin(PCin),
    .Zlowin(Zlowin), .Rin(Rin), .GRA(GRA), .GRB(GRB), .GRC(GRC), .IncPc(IncPc),
    .CONin(CONin), .read(read), .write(write), .run(run), .mdr_read(mdr_read),
    .control(control)
  );

  always #5 clk = ~clk;

  logic [26:0] got;
  assign got = {PCout, Zlowout, MDRout, Cout, BAout, Rout, MARin, MDRin, IRin, Yin, PCin,
                Zlowin, Rin, GRA, GRB, GRC, IncPc, CONin, read, write, run, mdr_read, control};

  localparam logic [26:0] O_PCOUT   = 27'd1 << 26;
  localparam logic [26:0] O_ZLOWOUT = 27'd1 << 25;
  localparam logic [26:0] O_MDROUT  = 27'd1 << 24;
  localparam logic [26:0] O_COUT    = 27'd1 << 23;
  localparam logic [26:0] O_BAOUT   = 27'd1 << 22;
  localparam logic [26:0] O_ROUT    = 27'd1 << 21;
  localparam logic [26:0] O_MARIN   = 27'd1 << 20;
  localparam logic [26:0] O_MDRIN   = 27'd1 << 19;
  localparam logic [26:0] O_IRIN    = 27'd1 << 18;
  localparam logic [26:0] O_YIN     = 27'd1 << 17;
  localparam logic [26:0] O_PCIN    = 27'd1 << 16;
  localparam logic [26:0] O_ZLOWIN  = 27'd1 << 15;
  localparam logic [26:0] O_RIN     = 27'd1 << 14;
  localparam logic [26:0] O_GRA     = 27'd1 << 13;
  localparam logic [26:0] O_GRB     = 27'd1 << 12;
  localparam logic [26:0] O_GRC     = 27'd1 << 11;
  localparam logic [26:0] O_INCPC   = 27'd1 << 10;
  localparam logic [26:0] O_CONIN   = 27'd1 << 9;
  localparam logic [26:0] O_READ    = 27'd1 << 8;
  localparam logic [26:0] O_WRITE   = 27'd1 << 7;
  localparam logic [26:0] O_RUN     = 27'd1 << 6;
  localparam logic [26:0] O_MDRMEM  = 27'd1 << 4;

  localparam logic [26:0] E_T0 = O_PCOUT | O_MARIN | O_INCPC | O_ZLOWIN | O_RUN;
  localparam logic [26:0] E_T1 = O_ZLOWOUT | O_PCIN | O_READ | O_MDRMEM | O_MDRIN | O_RUN;
  localparam logic [26:0] E_T2 = O_MDROUT | O_IRIN | O_RUN;

  typedef struct {
    string       name;
    logic [31:0] ir;
    logic        br;
    logic        mr;
    logic        st;
    logic [26:0] exp;
  } vec_t;

  vec_t q[$];
  int compared = 0;
  int mismatched = 0;

  task automatic check(input string nm, input logic [26:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %07h required %07h", nm, got, exp);
    end else begin
      $display("ok   %s: %07h", nm, got);
    end
  endtask

  task automatic push(input string nm, input logic [31:0] i, input logic b, input logic m,
                      input logic s, input logic [26:0] e);
    vec_t v;
    v.name = nm; v.ir = i; v.br = b; v.mr = m; v.st = s; v.exp = e;
    q.push_back(v);
  endtask

  // Fetch with 'waits' stalled T1 cycles; stop/mem_ready are toggled in T2 where they must be ignored.
  task automatic fetch(input string nm, input logic [31:0] i, input logic b, input int waits);
    push({nm, ":T0"}, i, b, 1'b1, 1'b0, E_T0);
    push({nm, ":T1"}, i, b, waits == 0, 1'b0, E_T1);
    for (int k = 1; k <= waits; k++)
      push({nm, ":T1w"}, i, b, k == waits, 1'b0, E_T1 & ~O_PCIN);
    push({nm, ":T2"}, i, b, 1'b0, 1'b1, E_T2);
  endtask

  task automatic alu(input string nm, input logic [31:0] i, input logic [3:0] ctl,
                     input logic imm, input logic s);
    fetch(nm, i, 1'b0, 0);
    push({nm, ":T3"}, i, 1'b0, 1'b1, 1'b0, O_GRB | O_ROUT | O_YIN | O_RUN);
    if (imm)
      push({nm, ":T4"}, i, 1'b0, 1'b1, 1'b0, O_COUT | O_ZLOWIN | O_RUN | 27'(ctl));
    else
      push({nm, ":T4"}, i, 1'b0, 1'b1, 1'b0, O_GRC | O_ROUT | O_ZLOWIN | O_RUN | 27'(ctl));
    push({nm, ":T5"}, i, 1'b0, 1'b1, s, O_ZLOWOUT | O_GRA | O_RIN | O_RUN);
  endtask

  task automatic addr_phase(input string nm, input logic [31:0] i);
    push({nm, ":T3"}, i, 1'b0, 1'b1, 1'b0, O_GRB | O_BAOUT | O_YIN | O_RUN);
    push({nm, ":T4"}, i, 1'b0, 1'b1, 1'b0, O_COUT | O_ZLOWIN | O_RUN | 27'd2);
    push({nm, ":T5"}, i, 1'b0, 1'b1, 1'b0, O_ZLOWOUT | O_MARIN | O_RUN);
  endtask

  task automatic br_instr(input string nm, input logic b);
    fetch(nm, 32'h9000_0000, b, 0);
    push({nm, ":T3"}, 32'h9000_0000, b, 1'b1, 1'b0, O_GRA | O_ROUT | O_CONIN | O_RUN);
    push({nm, ":T4"}, 32'h9000_0000, b, 1'b1, 1'b0, O_PCOUT | O_YIN | O_RUN);
    push({nm, ":T5"}, 32'h9000_0000, b, 1'b1, 1'b0, O_COUT | O_ZLOWIN | O_RUN | 27'd2);
    push({nm, ":T6"}, 32'h9000_0000, b, 1'b1, 1'b0, O_ZLOWOUT | (b ? O_PCIN : 27'd0) | O_RUN);
  endtask

  // Called at a falling edge; drives one vector, checks, returns at the next falling edge.
  task automatic run_q();
    for (int k = 0; k < q.size(); k++) begin
      ir = q[k].ir; branch = q[k].br; mem_ready = q[k].mr; stop = q[k].st;
      #1;
      check(q[k].name, q[k].exp);
      @(negedge clk);
    end
    q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("reset_asserted", 27'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ir = 32'd0; branch = 1'b0; mem_ready = 1'b0; stop = 1'b0;

    // Main vector table
    push("rst_state", 32'h1800_0000, 1'b0, 1'b1, 1'b0, 27'd0);
    alu("add", 32'h1800_0000, 4'd2, 1'b0, 1'b0);
    fetch("ld", 32'h0000_0000, 1'b0, 1);
    addr_phase("ld", 32'h0000_0000);
    for (int k = 0; k < 4; k++)
      push("ld:T6", 32'h0000_0000, 1'b0, k == 3, 1'b0, O_READ | O_MDRMEM | O_MDRIN | O_RUN);
    push("ld:T7", 32'h0000_0000, 1'b0, 1'b0, 1'b0, O_MDROUT | O_GRA | O_RIN | O_RUN);
    fetch("st", 32'h1000_0000, 1'b0, 0);
    addr_phase("st", 32'h1000_0000);
    push("st:T6", 32'h1000_0000, 1'b0, 1'b0, 1'b0, O_GRA | O_ROUT | O_MDRIN | O_RUN);
    push("st:T7", 32'h1000_0000, 1'b0, 1'b0, 1'b0, O_WRITE | O_RUN);
    push("st:T7", 32'h1000_0000, 1'b0, 1'b1, 1'b0, O_WRITE | O_RUN);
    alu("sub", 32'h2000_0000, 4'd3, 1'b0, 1'b0);
    alu("and", 32'h2800_0000, 4'd4, 1'b0, 1'b0);
    alu("or", 32'h3000_0000, 4'd5, 1'b0, 1'b0);
    alu("addi", 32'h5800_0000, 4'd2, 1'b1, 1'b0);
    alu("andi", 32'h6000_0000, 4'd4, 1'b1, 1'b0);
    alu("ori", 32'h6800_0000, 4'd5, 1'b1, 1'b0);
    br_instr("br0", 1'b0);
    br_instr("br1", 1'b1);
    fetch("jr", 32'h9800_0000, 1'b0, 0);
    push("jr:T3", 32'h9800_0000, 1'b0, 1'b1, 1'b0, O_GRA | O_ROUT | O_PCIN | O_RUN);
    fetch("jal", 32'hA000_0000, 1'b0, 0);
    push("jal:T3", 32'hA000_0000, 1'b0, 1'b1, 1'b0, O_GRB | O_PCOUT | O_RIN | O_RUN);
    push("jal:T4", 32'hA000_0000, 1'b0, 1'b1, 1'b0, O_GRA | O_ROUT | O_PCIN | O_RUN);
    fetch("nop", 32'hD000_0000, 1'b0, 0);
    push("nop:T3", 32'hD000_0000, 1'b0, 1'b1, 1'b0, O_RUN);
    fetch("undef01", 32'h0800_0000, 1'b0, 0);
    push("undef01:T3", 32'h0800_0000, 1'b0, 1'b1, 1'b0, O_RUN);
    alu("add_stop", 32'h1800_0000, 4'd2, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++)
      push("halt_by_stop", 32'h1800_0000, 1'b0, 1'b1, 1'b0, 27'd0);

    #2;
    check("por_outputs", 27'd0);
    @(negedge clk);
    reset = 1'b0;
    run_q();

    // Halt opcode, then reset back out of HALT
    do_reset();
    push("rst_state", 32'hD800_0000, 1'b0, 1'b1, 1'b0, 27'd0);
    fetch("halt", 32'hD800_0000, 1'b0, 0);
    push("halt:T3", 32'hD800_0000, 1'b0, 1'b1, 1'b0, O_RUN);
    for (int k = 0; k < 3; k++)
      push("halt_state", 32'hD800_0000, 1'b0, 1'b1, 1'b0, 27'd0);
    run_q();
    do_reset();
    push("rst_state", 32'h1000_0000, 1'b0, 1'b1, 1'b0, 27'd0);

    // st stalled in T7, then asynchronous reset between clock edges
    fetch("st2", 32'h1000_0000, 1'b0, 0);
    addr_phase("st2", 32'h1000_0000);
    push("st2:T6", 32'h1000_0000, 1'b0, 1'b1, 1'b0, O_GRA | O_ROUT | O_MDRIN | O_RUN);
    push("st2:T7", 32'h1000_0000, 1'b0, 1'b0, 1'b0, O_WRITE | O_RUN);
    run_q();
    mem_ready = 1'b0;
    #1;
    check("st2:T7_hold", O_WRITE | O_RUN);
    #2;
    reset = 1'b1;
    #1;
    check("async_abort", 27'd0);
    @(posedge clk);
    #1;
    check("abort_held", 27'd0);
    @(negedge clk);
    reset = 1'b0;
    push("rst_state", 32'hF800_0000, 1'b0, 1'b1, 1'b0, 27'd0);
    fetch("undef1f", 32'hF800_0000, 1'b0, 0);
    push("undef1f:T3", 32'hF800_0000, 1'b0, 1'b1, 1'b0, O_RUN);
    push("after_undef:T0", 32'hF800_0000, 1'b0, 1'b1, 1'b0, E_T0);
    run_q();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
